// File: rtl/robo_wall_follower.sv
// Wall-following controller: per-sensor sync (plus debounce filters when
// ROBO_WALL_DEBOUNCE_EN is defined), left/right wall selection, rotation
// timeout into a HALT fault state, enable gating and turn/lost-wall telemetry.
module robo_wall_follower #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ROT_TIMEOUT     = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             head,
  input  logic             left,
  input  logic             right,
  input  logic             side_sel,
  output logic             avancar,
  output logic             girar,
  output logic             girar_dir,
  output logic [1:0]       estado,
  output logic             fault,
  output logic             lost_wall,
  output logic [CNT_W-1:0] turn_count
);

  localparam int unsigned TMR_W = $clog2(ROT_TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    ROTATE = 2'b01,
    FOLLOW = 2'b10,
    HALT   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] rot_timer, timer_d;
  logic             lost_d;
  logic             enter_rot;
  logic [CNT_W-1:0] turn_d;
  logic             side_q;
  logic [2:0]       sync_v;   // {head, left, right} after one register stage
  logic [2:0]       filt;     // filtered {hf, lf, rf}
  logic             hf, lf, rf, w;

  // Single register stage on the raw sensor pins
  always_ff @(posedge clock) begin
    if (!reset) sync_v <= 3'b000;
    else        sync_v <= {head, left, right};
  end

`ifdef ROBO_WALL_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt [3];

  // Filter flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock) begin
    if (!reset) begin
      filt <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_v[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt[i]   <= sync_v[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end
`else
  // Without debounce the synchronised value is used directly
  assign filt = sync_v;
`endif

  assign hf = filt[2];
  assign lf = filt[1];
  assign rf = filt[0];
  assign w  = side_q ? rf : lf;

  // Wall side is latched while searching and frozen otherwise
  always_ff @(posedge clock) begin
    if (!reset)                 side_q <= 1'b0;
    else if (state_q == SEARCH) side_q <= side_sel;
  end

  // Next-state, rotation timer, lost-wall pulse and turn counter update
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    lost_d    = 1'b0;
    enter_rot = 1'b0;
    if (!enable) begin
      state_d = SEARCH;
    end else begin
      case (state_q)
        SEARCH: begin
          case ({hf, w})
            2'b01:   state_d = FOLLOW;
            2'b10,
            2'b11: begin
              state_d   = ROTATE;
              enter_rot = 1'b1;
            end
            default: state_d = SEARCH;
          endcase
        end
        ROTATE: begin
          // Exit wins over a timeout in the same cycle
          if ({hf, w} == 2'b01) begin
            state_d = FOLLOW;
          end else if (rot_timer == TMR_W'(ROT_TIMEOUT - 1)) begin
            state_d = HALT;
          end else begin
            timer_d = rot_timer + TMR_W'(1);
          end
        end
        FOLLOW: begin
          case ({hf, w})
            2'b01:   state_d = FOLLOW;
            2'b11: begin
              state_d   = ROTATE;
              enter_rot = 1'b1;
            end
            default: begin
              state_d = SEARCH;
              lost_d  = 1'b1;
            end
          endcase
        end
        HALT:    state_d = HALT;
        default: state_d = SEARCH;
      endcase
    end
    turn_d = turn_count;
    if (enter_rot && (turn_count != {CNT_W{1'b1}})) begin
      turn_d = turn_count + CNT_W'(1);
    end
  end

  // State and telemetry registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= SEARCH;
      rot_timer  <= '0;
      lost_wall  <= 1'b0;
      turn_count <= '0;
    end else begin
      state_q    <= state_d;
      rot_timer  <= timer_d;
      lost_wall  <= lost_d;
      turn_count <= turn_d;
    end
  end

  // Motor decode from the state register, forced off while disabled
  always_comb begin
    avancar   = 1'b0;
    girar     = 1'b0;
    girar_dir = 1'b0;
    if (enable) begin
      case (state_q)
        SEARCH:  avancar = 1'b1;
        ROTATE: begin
          girar     = 1'b1;
          girar_dir = ~side_q;
        end
        FOLLOW:  avancar = 1'b1;
        default: avancar = 1'b0;
      endcase
    end
  end

  assign estado = state_q;
  assign fault  = (state_q == HALT);

endmodule

// File: tb/tb_robo_wall_follower.sv
// Directed self-checking bench for robo_wall_follower (CNT_W=2 to reach saturation).
module tb_robo_wall_follower;

  localparam int DB = 4;
  localparam int TO = 16;
`ifdef ROBO_WALL_DEBOUNCE_EN
  localparam int LAT = DB + 2;
`else
  localparam int LAT = 2;
`endif

  logic       clock = 1'b0;
  logic       reset, enable, head, left, right, side_sel;
  logic       avancar, girar, girar_dir, fault, lost_wall;
  logic [1:0] estado;
  logic [1:0] turn_count;

  int checks   = 0;
  int failures = 0;

  robo_wall_follower #(
    .DEBOUNCE_CYCLES(DB),
    .ROT_TIMEOUT    (TO),
    .CNT_W          (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .head      (head),
    .left      (left),
    .right     (right),
    .side_sel  (side_sel),
    .avancar   (avancar),
    .girar     (girar),
    .girar_dir (girar_dir),
    .estado    (estado),
    .fault     (fault),
    .lost_wall (lost_wall),
    .turn_count(turn_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic s);
    reset = 1'b0; enable = 1'b0; head = 1'b0; left = 1'b0; right = 1'b0;
    side_sel = s;
    tick(); tick();
    reset = 1'b1; enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; head = 1'b0; left = 1'b0; right = 1'b0;
    side_sel = 1'b0;
    tick(); tick();
    checks++; if (estado !== 2'b00) begin failures++; $display("FAIL rst_estado got=%b exp=00", estado); end
    checks++; if ({avancar, girar} !== 2'b00) begin failures++; $display("FAIL rst_motors_disabled got=%b exp=00", {avancar, girar}); end
    checks++; if (lost_wall !== 1'b0) begin failures++; $display("FAIL rst_lost got=%b exp=0", lost_wall); end
    reset = 1'b1; enable = 1'b1;
    tick();
    checks++; if (estado !== 2'b00) begin failures++; $display("FAIL idle_estado got=%b exp=00", estado); end
    checks++; if ({avancar, girar} !== 2'b10) begin failures++; $display("FAIL idle_motors got=%b exp=10", {avancar, girar}); end
    checks++; if (turn_count !== 2'd0) begin failures++; $display("FAIL idle_turns got=%0d exp=0", turn_count); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL idle_fault got=%b exp=0", fault); end
  endtask

  task automatic test_left_follow();
    do_reset(1'b0);
    left = 1'b1;
    repeat (LAT - 1) tick();
    checks++; if (estado !== 2'b00) begin failures++; $display("FAIL lf_early got=%b exp=00", estado); end
    tick();
    checks++; if (estado !== 2'b10) begin failures++; $display("FAIL lf_follow got=%b exp=10", estado); end
    checks++; if ({avancar, girar} !== 2'b10) begin failures++; $display("FAIL lf_motors got=%b exp=10", {avancar, girar}); end
    left = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (estado !== 2'b10 || lost_wall !== 1'b0) begin failures++; $display("FAIL lf_hold got=%b/%b exp=10/0", estado, lost_wall); end
    tick();
    checks++; if (estado !== 2'b00 || lost_wall !== 1'b1) begin failures++; $display("FAIL lf_lost got=%b/%b exp=00/1", estado, lost_wall); end
    tick();
    checks++; if (lost_wall !== 1'b0) begin failures++; $display("FAIL lf_pulse_len got=%b exp=0", lost_wall); end
  endtask

  task automatic test_right_corner();
    do_reset(1'b1);
    right = 1'b1;
    repeat (LAT) tick();
    checks++; if (estado !== 2'b10) begin failures++; $display("FAIL rc_follow got=%b exp=10", estado); end
    head = 1'b1;
    repeat (LAT - 1) tick();
    checks++; if (estado !== 2'b10 || turn_count !== 2'd0) begin failures++; $display("FAIL rc_pre got=%b/%0d exp=10/0", estado, turn_count); end
    tick();
    checks++; if (estado !== 2'b01) begin failures++; $display("FAIL rc_rotate got=%b exp=01", estado); end
    checks++; if ({avancar, girar, girar_dir} !== 3'b010) begin failures++; $display("FAIL rc_motors got=%b exp=010", {avancar, girar, girar_dir}); end
    checks++; if (turn_count !== 2'd1) begin failures++; $display("FAIL rc_turns got=%0d exp=1", turn_count); end
    head = 1'b0;
    repeat (LAT) tick();
    checks++; if (estado !== 2'b10 || girar_dir !== 1'b0) begin failures++; $display("FAIL rc_back got=%b/%b exp=10/0", estado, girar_dir); end
    right = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    head = 1'b1;
    repeat (LAT) tick();
    checks++; if (estado !== 2'b01 || girar_dir !== 1'b1) begin failures++; $display("FAIL to_enter got=%b/%b exp=01/1", estado, girar_dir); end
    repeat (TO - 1) tick();
    checks++; if (estado !== 2'b01) begin failures++; $display("FAIL to_last_rotate got=%b exp=01", estado); end
    tick();
    checks++; if (estado !== 2'b11 || fault !== 1'b1) begin failures++; $display("FAIL to_halt got=%b/%b exp=11/1", estado, fault); end
    checks++; if ({avancar, girar} !== 2'b00) begin failures++; $display("FAIL to_halt_motors got=%b exp=00", {avancar, girar}); end
    enable = 1'b0;
    tick();
    checks++; if (estado !== 2'b00 || fault !== 1'b0) begin failures++; $display("FAIL to_disable got=%b/%b exp=00/0", estado, fault); end
    checks++; if ({avancar, girar, girar_dir} !== 3'b000) begin failures++; $display("FAIL to_dis_motors got=%b exp=000", {avancar, girar, girar_dir}); end
    enable = 1'b1;
    #1;
    checks++; if (avancar !== 1'b1) begin failures++; $display("FAIL to_reenable got=%b exp=1", avancar); end
    tick();
    checks++; if (estado !== 2'b01 || turn_count !== 2'd2) begin failures++; $display("FAIL to_rerotate got=%b/%0d exp=01/2", estado, turn_count); end
    head = 1'b0;
  endtask

  task automatic test_exit_at_timeout();
    do_reset(1'b0);
    head = 1'b1; left = 1'b1;
    repeat (LAT) tick();
    checks++; if (estado !== 2'b01) begin failures++; $display("FAIL ex_enter got=%b exp=01", estado); end
    repeat (TO - LAT) tick();
    head = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (estado !== 2'b01) begin failures++; $display("FAIL ex_pre got=%b exp=01", estado); end
    tick();
    checks++; if (estado !== 2'b10 || fault !== 1'b0) begin failures++; $display("FAIL ex_exit_wins got=%b/%b exp=10/0", estado, fault); end
    left = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset(1'b0);
`ifdef ROBO_WALL_DEBOUNCE_EN
    left = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) left = 1'b0;
      tick();
      checks++; if (estado !== 2'b00) begin failures++; $display("FAIL gl_short cyc=%0d got=%b exp=00", i, estado); end
    end
    left = 1'b1;
    repeat (4) tick();
    left = 1'b0;
    tick();
    checks++; if (estado !== 2'b00) begin failures++; $display("FAIL gl_long_pre got=%b exp=00", estado); end
    tick();
    checks++; if (estado !== 2'b10) begin failures++; $display("FAIL gl_long got=%b exp=10", estado); end
`else
    left = 1'b1;
    tick();
    left = 1'b0;
    tick();
    checks++; if (estado !== 2'b10) begin failures++; $display("FAIL gl_pass got=%b exp=10", estado); end
    tick();
    checks++; if (estado !== 2'b00 || lost_wall !== 1'b1) begin failures++; $display("FAIL gl_drop got=%b/%b exp=00/1", estado, lost_wall); end
`endif
  endtask

  task automatic test_saturation();
    logic [1:0] exp_tc [5];
    exp_tc[0] = 2'd1; exp_tc[1] = 2'd2; exp_tc[2] = 2'd3; exp_tc[3] = 2'd3; exp_tc[4] = 2'd3;
    do_reset(1'b0);
    head = 1'b1;
    repeat (LAT) tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        enable = 1'b0; tick();
        enable = 1'b1; tick();
      end
      checks++; if (estado !== 2'b01 || turn_count !== exp_tc[i]) begin failures++; $display("FAIL sat_%0d got=%b/%0d exp=01/%0d", i, estado, turn_count, exp_tc[i]); end
    end
    head = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_follow();
    test_right_corner();
    test_timeout();
    test_exit_at_timeout();
    test_glitch();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
